// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Bit positions inside the sticky cause register.
  localparam int CausePor = 0;
  localparam int CauseBtn = 1;
  localparam int CausePll = 2;
  localparam int CauseSw  = 3;
  localparam int CauseW   = 4;

  // Largest of three values; sizes the shared sequencing counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter, debounced
// level and a single-cycle pulse on the debounced rising edge.
module rst_debounce #(
  parameter int DebounceCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_db,
  output logic btn_evt
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [1:0]      sync;
  logic [CntW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous button input.
  // NOTE: every flop uses non-blocking assignments so all registers update
  // from pre-edge values, which is what makes the shift chain a real chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync <= 2'b00;
    else       sync <= {sync[0], btn_i};
  end

  // Count consecutive cycles the synced value differs from the debounced
  // one; adopt it once it has differed for DebounceCycles cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      btn_db  <= 1'b0;
      btn_evt <= 1'b0;
    end else begin
      btn_evt <= 1'b0;
      if (sync[1] == btn_db) begin
        cnt <= '0;
      end else if (cnt == CntLast) begin
        btn_db  <= sync[1];
        btn_evt <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: holds all domains in reset after any reset event,
// waits for a stable PLL lock, then releases the domains in index order
// with a fixed gap, recording the cause of the last reset.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NumDomains       = 4,
  parameter int HoldCycles       = 256,
  parameter int LockStableCycles = 64,
  parameter int StageGapCycles   = 16,
  parameter int DebounceCycles   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  btn_i,
  input  logic                  sw_rst_req_i,
  input  logic                  cause_clr_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  done_o,
  output logic [CauseW-1:0]     cause_o
);

  localparam int CntW = $clog2(max3(HoldCycles, LockStableCycles, StageGapCycles) + 1);
  localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LockStableCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGapCycles - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

  if (NumDomains < 1 || HoldCycles < 1 || LockStableCycles < 1 ||
      StageGapCycles < 1 || DebounceCycles < 1) begin : g_param_check
    $error("rst_seq: every parameter must be >= 1");
  end

  state_e              state;
  logic [CntW-1:0]     cnt;
  logic [IdxW-1:0]     idx;
  logic [1:0]          lock_sync;
  logic                lock_s;
  logic                btn_db;
  logic                btn_evt;
  logic [CauseW-1:0]   ev_bits;
  logic                abort;

  rst_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .btn_db (btn_db),
    .btn_evt(btn_evt)
  );

  // Two-stage synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll_locked_i};
  end

  assign lock_s = lock_sync[1];

  // Decode this cycle's reset events; lock loss only counts once release
  // has begun.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    ev_bits           = '0;
    ev_bits[CauseBtn] = btn_evt;
    ev_bits[CauseSw]  = sw_rst_req_i;
    ev_bits[CausePll] = !lock_s && (state == RELEASE || state == RUN);
    abort             = |ev_bits;
  end

  // Sequencer state machine with registered reset outputs and cause log.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_no  <= '0;
      done_o  <= 1'b0;
      cause_o <= CauseW'(1 << CausePor);
    end else begin
      // A new event bit survives a clear in the same cycle.
      cause_o <= (cause_clr_i ? '0 : cause_o) | ev_bits;

      case (state)
        HOLD: begin
          if (abort) begin
            cnt <= '0;
          end else if (cnt == HoldLast && !btn_db) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt != HoldLast) begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (abort) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LockLast) begin
            state <= RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE, RUN: begin
          if (abort) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_no <= '0;
            done_o <= 1'b0;
          end else if (state == RELEASE) begin
            if (cnt == GapLast) begin
              rst_no[idx] <= 1'b1;
              cnt         <= '0;
              idx         <= idx + 1'b1;
              if (idx == IdxLast) begin
                state  <= RUN;
                done_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with small parameters: a table of
// {cycles, inputs, expected outputs} rows plus hand-written reset steps.
module tb_rst_seq;

  localparam int ND = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          pll_locked_i = 1'b1;
  logic          btn_i = 1'b0;
  logic          sw_rst_req_i = 1'b0;
  logic          cause_clr_i = 1'b0;
  logic [ND-1:0] rst_no;
  logic          done_o;
  logic [3:0]    cause_o;

  int total  = 0;
  int passed = 0;

  rst_seq #(
    .NumDomains      (ND),
    .HoldCycles      (8),
    .LockStableCycles(4),
    .StageGapCycles  (2),
    .DebounceCycles  (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pll_locked_i(pll_locked_i),
    .btn_i       (btn_i),
    .sw_rst_req_i(sw_rst_req_i),
    .cause_clr_i (cause_clr_i),
    .rst_no      (rst_no),
    .done_o      (done_o),
    .cause_o     (cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]    n;
    logic          lock;
    logic          btn;
    logic          sw;
    logic          clr;
    logic [ND-1:0] rst_no;
    logic          done;
    logic [3:0]    cause;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int n, input bit lock, input bit btn,
                             input bit sw, input bit clr, input bit [2:0] r,
                             input bit d, input bit [3:0] c);
    vec_t x;
    x.n = 8'(n); x.lock = lock; x.btn = btn; x.sw = sw; x.clr = clr;
    x.rst_no = r; x.done = d; x.cause = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_outs(input string tag, input logic [ND-1:0] r,
                            input logic d, input logic [3:0] c);
    check({tag, " rst_no"},  32'(rst_no),  32'(r));
    check({tag, " done_o"},  32'(done_o),  32'(d));
    check({tag, " cause_o"}, 32'(cause_o), 32'(c));
  endtask

  // Inputs change on a falling edge; outputs are compared on the falling
  // edge after the row's n rising edges.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pll_locked_i = tbl[i].lock;
      btn_i        = tbl[i].btn;
      sw_rst_req_i = tbl[i].sw;
      cause_clr_i  = tbl[i].clr;
      repeat (int'(tbl[i].n)) @(posedge clk_i);
      @(negedge clk_i);
      sw_rst_req_i = 1'b0;
      cause_clr_i  = 1'b0;
      check_outs($sformatf("row%0d", i), tbl[i].rst_no, tbl[i].done, tbl[i].cause);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // POR, lock present: hold 8, lock-wait 4, then +2/+4/+6 releases.
    tbl.push_back(v(7,  1,0,0,0, 3'b000,0,4'b0001)); // 0  edge 7
    tbl.push_back(v(1,  1,0,0,0, 3'b000,0,4'b0001)); // 1  edge 8
    tbl.push_back(v(5,  1,0,0,0, 3'b000,0,4'b0001)); // 2  edge 13
    tbl.push_back(v(1,  1,0,0,0, 3'b001,0,4'b0001)); // 3  edge 14
    tbl.push_back(v(1,  1,0,0,0, 3'b001,0,4'b0001)); // 4
    tbl.push_back(v(1,  1,0,0,0, 3'b011,0,4'b0001)); // 5  edge 16
    tbl.push_back(v(1,  1,0,0,0, 3'b011,0,4'b0001)); // 6
    tbl.push_back(v(1,  1,0,0,0, 3'b111,1,4'b0001)); // 7  edge 18
    tbl.push_back(v(3,  1,0,0,0, 3'b111,1,4'b0001)); // 8
    // Short press (3 cycles) is filtered out.
    tbl.push_back(v(3,  1,1,0,0, 3'b111,1,4'b0001)); // 9
    tbl.push_back(v(6,  1,0,0,0, 3'b111,1,4'b0001)); // 10
    // Long press: debounced after sync(2)+4, abort one cycle later.
    tbl.push_back(v(6,  1,1,0,0, 3'b111,1,4'b0001)); // 11
    tbl.push_back(v(1,  1,1,0,0, 3'b000,0,4'b0011)); // 12
    tbl.push_back(v(13, 1,1,0,0, 3'b000,0,4'b0011)); // 13 held button keeps HOLD
    tbl.push_back(v(12, 1,0,0,0, 3'b000,0,4'b0011)); // 14
    tbl.push_back(v(1,  1,0,0,0, 3'b001,0,4'b0011)); // 15
    tbl.push_back(v(4,  1,0,0,0, 3'b111,1,4'b0011)); // 16
    // Software request from RUN, then walk back into RELEASE.
    tbl.push_back(v(1,  1,0,1,0, 3'b000,0,4'b1011)); // 17
    tbl.push_back(v(14, 1,0,0,0, 3'b001,0,4'b1011)); // 18
    // After a fresh POR: 2-cycle lock glitch early in WAIT_LOCK.
    tbl.push_back(v(8,  1,0,0,0, 3'b000,0,4'b0001)); // 19 edge 8
    tbl.push_back(v(2,  0,0,0,0, 3'b000,0,4'b0001)); // 20 edge 10
    tbl.push_back(v(4,  1,0,0,0, 3'b000,0,4'b0001)); // 21 edge 14 (nominal 001)
    tbl.push_back(v(3,  1,0,0,0, 3'b000,0,4'b0001)); // 22 edge 17
    tbl.push_back(v(1,  0,0,0,0, 3'b001,0,4'b0001)); // 23 edge 18
    tbl.push_back(v(1,  0,0,0,0, 3'b001,0,4'b0001)); // 24 edge 19
    // Synced lock loss coincident with software request.
    tbl.push_back(v(1,  0,0,1,0, 3'b000,0,4'b1101)); // 25 edge 20
    tbl.push_back(v(1,  0,0,0,0, 3'b000,0,4'b1101)); // 26 lock loss in HOLD: no cause
    tbl.push_back(v(1,  1,0,0,1, 3'b000,0,4'b0000)); // 27 clear alone
    tbl.push_back(v(1,  1,0,1,1, 3'b000,0,4'b1000)); // 28 event beats clear
    tbl.push_back(v(3,  1,0,0,0, 3'b000,0,4'b1000)); // 29

    // Reset state while rst_i is held.
    repeat (3) @(negedge clk_i);
    check_outs("por", 3'b000, 1'b0, 4'b0001);
    rst_i = 1'b0;
    run_rows(0, 18);

    // Asynchronous reset in the middle of RELEASE: outputs drop without a clock.
    rst_i = 1'b1;
    #1;
    check_outs("async_rst", 3'b000, 1'b0, 4'b0001);
    repeat (2) @(negedge clk_i);
    check_outs("rst_held", 3'b000, 1'b0, 4'b0001);
    rst_i = 1'b0;
    run_rows(19, 29);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
